enigma_step_ctrl: RTL and testbench
===================================

ENIGMA_STEP_CTRL -- requirements
Module: enigma_step_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles waited after stepping before sampling the rotor path (legal 1-15).
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port key_in, input, 26, meaning one-hot plaintext letter (bit 0 = A).
REQ-005 SHALL have port key_valid, input, 1, meaning key_in is presented this cycle.
REQ-006 SHALL have port key_ready, output, 1, meaning the controller is idle and accepts a key.
REQ-007 SHALL have port cfg_load, input, 1, meaning load rotor selection and start positions.
REQ-008 SHALL have port cfg_sel_l / cfg_sel_m / cfg_sel_r, input, 2 each, meaning rotor type per slot (00 = I, 01 = II, 10 = III, 11 = no encryption).
REQ-009 SHALL have port cfg_pos_l / cfg_pos_m / cfg_pos_r, input, 5 each, meaning start position per slot (0 = A .. 25 = Z).
REQ-010 SHALL have port wiring_l / wiring_m / wiring_r, output, 2 each, meaning the registered wiring_config driven to each rotor.
REQ-011 SHALL have port rotate_l / rotate_m / rotate_r, output, 1 each, meaning a one-cycle step pulse to each rotor.
REQ-012 SHALL have port pos_l / pos_m / pos_r, output, 5 each, meaning the mirrored current rotor positions.
REQ-013 SHALL have port key_out, output, 26, meaning the letter driven into the rotor path.
REQ-014 SHALL have port path_in, input, 26, meaning the one-hot result returned from the rotor/reflector path.
REQ-015 SHALL have port lamp, output, 26, meaning the last captured ciphertext letter.
REQ-016 SHALL have port lamp_valid, output, 1, meaning a one-cycle pulse marking a new lamp value.
REQ-017 SHALL have port key_err, output, 1, meaning a one-cycle pulse when a rejected key is presented.

Function
REQ-018 SHALL implement FSM states IDLE, STEP, SETTLE, CAPTURE; key_ready = 1 only in IDLE.
REQ-019 In IDLE, key_valid with key_in exactly one-hot SHALL latch key_in into key_out and move to STEP; key_out SHALL be 0 while in IDLE.
REQ-020 In IDLE, key_valid with key_in zero or multi-hot SHALL be dropped, pulse key_err for one cycle, and stay in IDLE.
REQ-021 key_valid outside IDLE SHALL be ignored: no error, no queueing.
REQ-022 In IDLE, cfg_load SHALL load the wiring and position registers at the next edge; position inputs 26-31 SHALL load as 0; cfg_load outside IDLE SHALL be ignored.
REQ-023 Simultaneous cfg_load and valid key_valid in IDLE: the configuration SHALL load first, and the key SHALL be accepted in the same cycle and stepped from the newly loaded positions.
REQ-024 Notch per slot SHALL be asserted when that slot's position equals 17 (R) for type 00, 5 (F) for type 01, or 22 (W) for type 10; a slot of type 11 never notches.
REQ-025 In STEP (exactly one cycle), step decisions SHALL use pre-step positions: rotate_r = 1; rotate_m = notch_r OR notch_m (double step); rotate_l = notch_m.
REQ-026 Each stepped position SHALL increment by 1 modulo 26 (25 -> 0) at the end of STEP; rotate pulses SHALL be low in every other state.
REQ-027 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to CAPTURE.
REQ-028 In CAPTURE (one cycle), lamp SHALL register path_in, the FSM SHALL return to IDLE, and lamp_valid SHALL be high for the following single cycle.
REQ-029 Latency from the key-accept edge to lamp_valid high SHALL be SETTLE_CYCLES + 2 edges (6 at default).
REQ-030 lamp SHALL hold its value until the next capture.

Reset
REQ-031 On reset high at a clock edge, from any state including mid-operation: state = IDLE; positions = 0; wiring = 11; key_out = 0; lamp = 0; all rotate pulses, lamp_valid and key_err = 0; key_ready = 1 in the cycle after.
REQ-032 Reset SHALL take priority over cfg_load and key_valid in the same cycle.

Verification
REQ-033 Double step: cfg (00, 01, 10), positions (0, 4, 21), keys A, A, A -> positions (0,4,22), (0,5,23), (1,6,24); rotate_m and rotate_l both pulse on the third key.
REQ-034 Wrap: right slot type 11, pos_r = 25, one key -> pos_r = 0, rotate_m = 0, rotate_l = 0.
REQ-035 Latency: default parameter, key C accepted, path_in held at 26'h0000010 -> lamp_valid high exactly 6 edges later, lamp = 26'h0000010, key_ready low throughout.
REQ-036 Reject: key_in = 26'h0000003 with key_valid -> key_err pulses once, no rotate pulse, positions unchanged; key_valid during SETTLE -> ignored.
REQ-037 Reset mid-SETTLE after a cfg_load to positions (3, 7, 9) -> next cycle IDLE, positions (0, 0, 0), wiring 11, no lamp_valid.
REQ-038 cfg_load with cfg_pos_r = 30 -> pos_r = 0; cfg_load during STEP -> ignored.

Source files
------------

// File: rtl/enigma_step_ctrl.sv
// Enigma keyboard/stepping controller: accepts one-hot keys, steps three rotors
// with double-step behaviour, waits for the rotor path to settle and captures the lamp.
module enigma_step_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [25:0] key_in,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        cfg_load,
    input  logic [1:0]  cfg_sel_l,
    input  logic [1:0]  cfg_sel_m,
    input  logic [1:0]  cfg_sel_r,
    input  logic [4:0]  cfg_pos_l,
    input  logic [4:0]  cfg_pos_m,
    input  logic [4:0]  cfg_pos_r,
    output logic [1:0]  wiring_l,
    output logic [1:0]  wiring_m,
    output logic [1:0]  wiring_r,
    output logic        rotate_l,
    output logic        rotate_m,
    output logic        rotate_r,
    output logic [4:0]  pos_l,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_r,
    output logic [25:0] key_out,
    input  logic [25:0] path_in,
    output logic [25:0] lamp,
    output logic        lamp_valid,
    output logic        key_err
);

    typedef enum logic [1:0] {IDLE, STEP, SETTLE, CAPTURE} state_t;

    // Slot index: 0 = right, 1 = middle, 2 = left
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0][1:0] wiring_q, wiring_d;
    logic [2:0][4:0] pos_q, pos_d;
    logic [2:0]      rotate_q, rotate_d;
    logic [25:0]     key_out_q, key_out_d;
    logic [25:0]     lamp_q, lamp_d;
    logic            lamp_valid_q, lamp_valid_d;
    logic            key_err_q, key_err_d;

    logic [2:0][1:0] eff_wiring;
    logic [2:0][4:0] eff_pos;
    logic            key_onehot;

    function automatic logic [4:0] clamp_pos(input logic [4:0] p);
        return (p > 5'd25) ? '0 : p;
    endfunction

    function automatic logic [4:0] inc_pos(input logic [4:0] p);
        return (p == 5'd25) ? '0 : p + 5'd1;
    endfunction

    function automatic logic notch(input logic [1:0] t, input logic [4:0] p);
        case (t)
            2'b00:   return p == 5'd17;
            2'b01:   return p == 5'd5;
            2'b10:   return p == 5'd22;
            default: return 1'b0;
        endcase
    endfunction

    assign key_onehot = (key_in != '0) && ((key_in & (key_in - 26'd1)) == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wiring_d     = wiring_q;
        pos_d        = pos_q;
        rotate_d     = '0;
        key_out_d    = key_out_q;
        lamp_d       = lamp_q;
        lamp_valid_d = 1'b0;
        key_err_d    = 1'b0;
        eff_wiring   = wiring_q;
        eff_pos      = pos_q;

        case (state_q)
            IDLE: begin
                key_out_d = '0;
                // A key arriving with cfg_load steps from the freshly loaded settings
                if (cfg_load) begin
                    eff_wiring = {cfg_sel_l, cfg_sel_m, cfg_sel_r};
                    eff_pos    = {clamp_pos(cfg_pos_l), clamp_pos(cfg_pos_m),
                                  clamp_pos(cfg_pos_r)};
                    wiring_d   = eff_wiring;
                    pos_d      = eff_pos;
                end
                if (key_valid) begin
                    if (key_onehot) begin
                        key_out_d   = key_in;
                        state_d     = STEP;
                        rotate_d[0] = 1'b1;
                        rotate_d[1] = notch(eff_wiring[0], eff_pos[0]) |
                                      notch(eff_wiring[1], eff_pos[1]);
                        rotate_d[2] = notch(eff_wiring[1], eff_pos[1]);
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
            STEP: begin
                pos_d[0] = rotate_q[0] ? inc_pos(pos_q[0]) : pos_q[0];
                pos_d[1] = rotate_q[1] ? inc_pos(pos_q[1]) : pos_q[1];
                pos_d[2] = rotate_q[2] ? inc_pos(pos_q[2]) : pos_q[2];
                cnt_d    = 4'(SETTLE_CYCLES - 1);
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CAPTURE: begin
                lamp_d       = path_in;
                lamp_valid_d = 1'b1;
                key_out_d    = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wiring_q     <= '1;
            pos_q        <= '0;
            rotate_q     <= '0;
            key_out_q    <= '0;
            lamp_q       <= '0;
            lamp_valid_q <= 1'b0;
            key_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wiring_q     <= wiring_d;
            pos_q        <= pos_d;
            rotate_q     <= rotate_d;
            key_out_q    <= key_out_d;
            lamp_q       <= lamp_d;
            lamp_valid_q <= lamp_valid_d;
            key_err_q    <= key_err_d;
        end
    end

    assign key_ready  = (state_q == IDLE);
    assign wiring_r   = wiring_q[0];
    assign wiring_m   = wiring_q[1];
    assign wiring_l   = wiring_q[2];
    assign pos_r      = pos_q[0];
    assign pos_m      = pos_q[1];
    assign pos_l      = pos_q[2];
    assign rotate_r   = rotate_q[0];
    assign rotate_m   = rotate_q[1];
    assign rotate_l   = rotate_q[2];
    assign key_out    = key_out_q;
    assign lamp       = lamp_q;
    assign lamp_valid = lamp_valid_q;
    assign key_err    = key_err_q;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed self-checking bench for enigma_step_ctrl (default settle of 4 cycles).
module tb_enigma_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [25:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic        cfg_load;
    logic [1:0]  cfg_sel_l, cfg_sel_m, cfg_sel_r;
    logic [4:0]  cfg_pos_l, cfg_pos_m, cfg_pos_r;
    logic [1:0]  wiring_l, wiring_m, wiring_r;
    logic        rotate_l, rotate_m, rotate_r;
    logic [4:0]  pos_l, pos_m, pos_r;
    logic [25:0] key_out;
    logic [25:0] path_in;
    logic [25:0] lamp;
    logic        lamp_valid;
    logic        key_err;

    logic [14:0] pos_all;
    logic [5:0]  wir_all;
    logic [2:0]  rot_all;

    int checks = 0;
    int errors = 0;

    assign pos_all = {pos_l, pos_m, pos_r};
    assign wir_all = {wiring_l, wiring_m, wiring_r};
    assign rot_all = {rotate_l, rotate_m, rotate_r};

    always #5 clk = ~clk;

    enigma_step_ctrl #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .cfg_load(cfg_load),
        .cfg_sel_l(cfg_sel_l), .cfg_sel_m(cfg_sel_m), .cfg_sel_r(cfg_sel_r),
        .cfg_pos_l(cfg_pos_l), .cfg_pos_m(cfg_pos_m), .cfg_pos_r(cfg_pos_r),
        .wiring_l(wiring_l), .wiring_m(wiring_m), .wiring_r(wiring_r),
        .rotate_l(rotate_l), .rotate_m(rotate_m), .rotate_r(rotate_r),
        .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
        .key_out(key_out), .path_in(path_in),
        .lamp(lamp), .lamp_valid(lamp_valid), .key_err(key_err)
    );

    function automatic logic [14:0] p3(input int l, input int m, input int r);
        return {5'(l), 5'(m), 5'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] sl, input logic [1:0] sm, input logic [1:0] sr,
                           input logic [4:0] pl, input logic [4:0] pm, input logic [4:0] pr);
        cfg_load  = 1'b1;
        cfg_sel_l = sl; cfg_sel_m = sm; cfg_sel_r = sr;
        cfg_pos_l = pl; cfg_pos_m = pm; cfg_pos_r = pr;
    endtask

    // Press one key and follow it through to lamp_valid; poke drives an
    // invalid key during SETTLE which must be ignored.
    task automatic press(input string tag, input logic [25:0] k, input logic [2:0] exp_rot,
                         input logic [14:0] exp_pos, input logic [25:0] path, input bit poke);
        int lat;
        bit busy_ok;
        path_in   = path;
        key_in    = k;
        key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        cfg_load  = 1'b0;
        chk({tag, ".rot"}, 32'(rot_all), 32'(exp_rot));
        chk({tag, ".kout"}, 32'(key_out), 32'(k));
        lat = 0;
        busy_ok = 1'b1;
        while (!lamp_valid && lat < 30) begin
            if (key_ready) busy_ok = 1'b0;
            if (poke && lat == 3) begin
                key_in    = 26'h3;
                key_valid = 1'b1;
            end
            tick;
            key_valid = 1'b0;
            lat++;
            if (lat == 1) chk({tag, ".pos"}, 32'(pos_all), 32'(exp_pos));
            if (lat == 4) chk({tag, ".noerr"}, 32'(key_err), 32'd0);
        end
        chk({tag, ".lat"}, lat, 6);
        chk({tag, ".busy"}, 32'(busy_ok), 32'd1);
        chk({tag, ".lamp"}, 32'(lamp), 32'(path));
        tick;
        chk({tag, ".lvdrop"}, {31'd0, lamp_valid}, 32'd0);
        chk({tag, ".ready"}, {31'd0, key_ready}, 32'd1);
        chk({tag, ".hold"}, 32'(lamp), 32'(path));
    endtask

    initial begin
        int n;
        bit seen;
        reset = 1'b1; key_in = '0; key_valid = 1'b0; cfg_load = 1'b0; path_in = '0;
        cfg_sel_l = '0; cfg_sel_m = '0; cfg_sel_r = '0;
        cfg_pos_l = '0; cfg_pos_m = '0; cfg_pos_r = '0;
        tick; tick;
        reset = 1'b0;
        chk("rst.ready", {31'd0, key_ready}, 32'd1);
        chk("rst.pos", 32'(pos_all), 32'd0);
        chk("rst.wir", 32'(wir_all), 32'h3f);
        chk("rst.kout", 32'(key_out), 32'd0);
        chk("rst.lamp", 32'(lamp), 32'd0);
        chk("rst.pulses", {28'd0, rot_all, lamp_valid | key_err}, 32'd0);

        // Double step sequence
        set_cfg(2'b00, 2'b01, 2'b10, 5'd0, 5'd4, 5'd21);
        tick;
        cfg_load = 1'b0;
        chk("ds.wir", 32'(wir_all), 32'b00_01_10);
        chk("ds.pos0", 32'(pos_all), 32'(p3(0, 4, 21)));
        press("ds1", 26'h1, 3'b001, p3(0, 4, 22), 26'h0000010, 1'b0);
        press("ds2", 26'h1, 3'b011, p3(0, 5, 23), 26'h0000200, 1'b0);
        press("ds3", 26'h1, 3'b111, p3(1, 6, 24), 26'h2000000, 1'b0);

        // Rejected keys: multi-hot and zero
        key_in = 26'h3; key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        chk("rej.err", {31'd0, key_err}, 32'd1);
        chk("rej.rot", 32'(rot_all), 32'd0);
        chk("rej.ready", {31'd0, key_ready}, 32'd1);
        chk("rej.pos", 32'(pos_all), 32'(p3(1, 6, 24)));
        tick;
        chk("rej.pulse", {31'd0, key_err}, 32'd0);
        key_in = 26'h0; key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        chk("rej0.err", {31'd0, key_err}, 32'd1);
        chk("rej0.ready", {31'd0, key_ready}, 32'd1);

        // Wrap with an unencrypted right slot; latency with key C; key during SETTLE ignored
        set_cfg(2'b00, 2'b00, 2'b11, 5'd0, 5'd0, 5'd25);
        tick;
        cfg_load = 1'b0;
        chk("wrap.pos0", 32'(pos_all), 32'(p3(0, 0, 25)));
        press("wrap", 26'h4, 3'b001, p3(0, 0, 0), 26'h0000010, 1'b1);
        chk("wrap.nostep", 32'(pos_all), 32'(p3(0, 0, 0)));

        // Out-of-range position loads as 0, then cfg_load during STEP is ignored
        set_cfg(2'b01, 2'b10, 2'b00, 5'd2, 5'd3, 5'd30);
        tick;
        cfg_load = 1'b0;
        chk("clamp.pos", 32'(pos_all), 32'(p3(2, 3, 0)));
        chk("clamp.wir", 32'(wir_all), 32'b01_10_00);
        key_in = 26'h8; key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        set_cfg(2'b11, 2'b11, 2'b11, 5'd9, 5'd9, 5'd9);
        tick;
        cfg_load = 1'b0;
        chk("stepcfg.wir", 32'(wir_all), 32'b01_10_00);
        chk("stepcfg.pos", 32'(pos_all), 32'(p3(2, 3, 1)));
        n = 0;
        while (!lamp_valid && n < 30) begin
            tick;
            n++;
        end
        chk("stepcfg.done", {31'd0, lamp_valid}, 32'd1);
        tick;

        // Simultaneous cfg_load and key: stepping uses the newly loaded positions
        set_cfg(2'b00, 2'b01, 2'b10, 5'd0, 5'd4, 5'd22);
        press("simul", 26'h10, 3'b011, p3(0, 5, 23), 26'h0000001, 1'b0);

        // Reset in the middle of SETTLE
        set_cfg(2'b00, 2'b01, 2'b10, 5'd3, 5'd7, 5'd9);
        tick;
        cfg_load = 1'b0;
        chk("mid.pos0", 32'(pos_all), 32'(p3(3, 7, 9)));
        key_in = 26'h1; key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid.ready", {31'd0, key_ready}, 32'd1);
        chk("mid.pos", 32'(pos_all), 32'd0);
        chk("mid.wir", 32'(wir_all), 32'h3f);
        chk("mid.kout", 32'(key_out), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (lamp_valid) seen = 1'b1;
            tick;
        end
        chk("mid.nolamp", {31'd0, seen}, 32'd0);

        // Reset beats cfg_load and key_valid in the same cycle
        set_cfg(2'b00, 2'b00, 2'b00, 5'd5, 5'd5, 5'd5);
        key_in = 26'h2; key_valid = 1'b1; reset = 1'b1;
        tick;
        reset = 1'b0; key_valid = 1'b0; cfg_load = 1'b0;
        chk("rprio.pos", 32'(pos_all), 32'd0);
        chk("rprio.ready", {31'd0, key_ready}, 32'd1);
        chk("rprio.wir", 32'(wir_all), 32'h3f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
